// File: rtl/screen_controller.sv
// Drawing sequencer: one full-screen clear, then an endless sweeping line
// animation (draw, hold, erase, advance) onto a registered framebuffer port.
module screen_controller #(
   parameter int HOLD_CYCLES = 1_000_000,
   parameter int STEP        = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        clear_en,
   input  logic [10:0] clear_x,
   input  logic [10:0] clear_y,
   input  logic        clear_done,
   output logic        line_start,
   output logic [10:0] line_x0,
   output logic [10:0] line_y0,
   output logic [10:0] line_x1,
   output logic [10:0] line_y1,
   input  logic [10:0] line_x,
   input  logic [10:0] line_y,
   input  logic        line_valid,
   input  logic        line_done,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        pixel_color,
   output logic        pixel_write
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_DRAW,
      S_HOLD,
      S_ERASE,
      S_STEP
   } state_t;

   localparam logic [10:0] XMAX      = 11'd639;
   localparam logic [10:0] YMAX      = 11'd479;
   localparam logic [10:0] STEP_W    = 11'(STEP);
   localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);

   state_t      state, state_n;
   logic [9:0]  pos, pos_n;
   logic [31:0] cnt, cnt_n;
   logic [10:0] sum;
   logic        clear_en_n, line_start_n;
   logic [10:0] x0_n, y0_n, x1_n, y1_n;
   logic [10:0] x_n, y_n;
   logic        color_n, write_n;

   assign busy = (state != S_IDLE);
   assign sum  = {1'b0, pos} + STEP_W;

   // Next-state, position/counter updates and the next write-port value.
   always_comb begin
      state_n      = state;
      pos_n        = pos;
      cnt_n        = cnt;
      clear_en_n   = clear_en;
      line_start_n = 1'b0;
      x0_n         = line_x0;
      y0_n         = line_y0;
      x1_n         = line_x1;
      y1_n         = line_y1;
      x_n          = x;
      y_n          = y;
      color_n      = pixel_color;
      write_n      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n    = S_CLEAR;
               clear_en_n = 1'b1;
            end
         end
         S_CLEAR: begin
            if (clear_done) begin
               clear_en_n   = 1'b0;
               pos_n        = '0;
               line_start_n = 1'b1;
               x0_n         = '0;
               y0_n         = '0;
               x1_n         = XMAX;
               y1_n         = YMAX;
               state_n      = S_DRAW;
            end else begin
               x_n     = clear_x;
               y_n     = clear_y;
               color_n = 1'b0;
               write_n = 1'b1;
            end
         end
         S_DRAW: begin
            if (line_valid) begin
               x_n     = line_x;
               y_n     = line_y;
               color_n = 1'b1;
               write_n = 1'b1;
            end
            if (line_done) begin
               cnt_n   = HOLD_LOAD;
               state_n = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt == '0) begin
               line_start_n = 1'b1;
               state_n      = S_ERASE;
            end else begin
               cnt_n = cnt - 32'd1;
            end
         end
         S_ERASE: begin
            if (line_valid) begin
               x_n     = line_x;
               y_n     = line_y;
               color_n = 1'b0;
               write_n = 1'b1;
            end
            if (line_done) begin
               pos_n   = (sum > XMAX) ? 10'd0 : sum[9:0];
               state_n = S_STEP;
            end
         end
         S_STEP: begin
            line_start_n = 1'b1;
            x0_n         = {1'b0, pos};
            y0_n         = '0;
            x1_n         = XMAX - {1'b0, pos};
            y1_n         = YMAX;
            state_n      = S_DRAW;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State, animation registers and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         pos         <= '0;
         cnt         <= '0;
         clear_en    <= 1'b0;
         line_start  <= 1'b0;
         line_x0     <= '0;
         line_y0     <= '0;
         line_x1     <= '0;
         line_y1     <= '0;
         x           <= '0;
         y           <= '0;
         pixel_color <= 1'b0;
         pixel_write <= 1'b0;
      end else begin
         state       <= state_n;
         pos         <= pos_n;
         cnt         <= cnt_n;
         clear_en    <= clear_en_n;
         line_start  <= line_start_n;
         line_x0     <= x0_n;
         line_y0     <= y0_n;
         line_x1     <= x1_n;
         line_y1     <= y1_n;
         x           <= x_n;
         y           <= y_n;
         pixel_color <= color_n;
         pixel_write <= write_n;
      end
   end

endmodule

// File: tb/tb_screen_controller.sv
// Bench for screen_controller: stub clear/line engines feed a write
// scoreboard; handshake timing and endpoints are checked directly.
module tb_screen_controller;

   localparam int HOLD      = 4;
   localparam int STEPV     = 160;
   localparam int SKIP_FROM = 1199;
   localparam int SKIP_TO   = 307160;
   localparam int CLR_WR    = (SKIP_FROM + 1) + (307200 - SKIP_TO);

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        clear_en;
   logic [10:0] clear_x, clear_y;
   logic        clear_done;
   logic        line_start;
   logic [10:0] line_x0, line_y0, line_x1, line_y1;
   logic [10:0] line_x, line_y;
   logic        line_valid, line_done;
   logic [10:0] x, y;
   logic        pixel_color, pixel_write;

   int          checks = 0;
   int          errors = 0;
   logic [22:0] sb[$];
   int          wr_count = 0;
   logic [22:0] first_w = '0;
   logic [22:0] last_w = '0;

   int          cidx = 0;
   logic        cdone_r = 1'b0;
   logic        spur_done = 1'b0;
   int          exp_pos;
   int          cyc;

   always #5 clk = ~clk;

   screen_controller #(.HOLD_CYCLES(HOLD), .STEP(STEPV)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .clear_en(clear_en), .clear_x(clear_x), .clear_y(clear_y),
      .clear_done(clear_done), .line_start(line_start),
      .line_x0(line_x0), .line_y0(line_y0),
      .line_x1(line_x1), .line_y1(line_y1),
      .line_x(line_x), .line_y(line_y),
      .line_valid(line_valid), .line_done(line_done),
      .x(x), .y(y), .pixel_color(pixel_color),
      .pixel_write(pixel_write)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Clear engine stub: raster order with a jump that skips most of the
   // frame, still ending on (639,479) and wrapping to (0,0) with done.
   always @(posedge clk) begin
      if (!clear_en) begin
         cidx    <= 0;
         cdone_r <= 1'b0;
      end else if (cidx == 307199) begin
         cidx    <= 0;
         cdone_r <= 1'b1;
      end else begin
         cidx    <= (cidx == SKIP_FROM) ? SKIP_TO : cidx + 1;
         cdone_r <= 1'b0;
      end
   end

   assign clear_x    = clear_en ? 11'(cidx % 640) : 11'd0;
   assign clear_y    = clear_en ? 11'(cidx / 640) : 11'd0;
   assign clear_done = (clear_en & cdone_r) | spur_done;

   // Write monitor: pop and compare each write, then record clear stimulus.
   always @(negedge clk) begin
      logic [22:0] e;
      if (pixel_write) begin
         if (wr_count == 0) first_w = {x, y, pixel_color};
         last_w = {x, y, pixel_color};
         wr_count++;
         check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("write", 64'({x, y, pixel_color}), 64'(e));
         end
      end
      if (clear_en && !clear_done)
         sb.push_back({clear_x, clear_y, 1'b0});
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_clear_en"}, 64'(clear_en), 64'd0);
      check({tag, "_line_start"}, 64'(line_start), 64'd0);
      check({tag, "_ends"},
            64'({line_x0, line_y0, line_x1, line_y1}), 64'd0);
      check({tag, "_xy"}, 64'({x, y}), 64'd0);
      check({tag, "_color"}, 64'(pixel_color), 64'd0);
      check({tag, "_write"}, 64'(pixel_write), 64'd0);
   endtask

   task automatic wait_ls(input int limit, input bit spur, output int n);
      n = 0;
      while (n < limit) begin
         spur_done = spur && (n == 1);
         @(posedge clk); #1;
         n++;
         if (line_start) break;
      end
      spur_done = 1'b0;
      check("line_start_seen", 64'(line_start), 64'd1);
   endtask

   task automatic check_ends(input string tag, input int p);
      check({tag, "_x0"}, 64'(line_x0), 64'(p));
      check({tag, "_y0"}, 64'(line_y0), 64'd0);
      check({tag, "_x1"}, 64'(line_x1), 64'(639 - p));
      check({tag, "_y1"}, 64'(line_y1), 64'd479);
   endtask

   task automatic check_pulse();
      @(posedge clk); #1;
      check("line_start_width", 64'(line_start), 64'd0);
   endtask

   task automatic drive_line(input int n, input int base, input logic color,
                             input bit coincide, input bit poke);
      for (int i = 0; i < n; i++) begin
         line_valid = 1'b1;
         line_x     = 11'(base + i * 7);
         line_y     = 11'(i * 5 + 1);
         sb.push_back({line_x, line_y, color});
         line_done  = coincide && (i == n - 1);
         start      = poke && (i == 0);
         @(posedge clk); #1;
      end
      line_valid = 1'b0;
      start      = 1'b0;
      if (!coincide) begin
         line_done = 1'b1;
         @(posedge clk); #1;
      end
      line_done = 1'b0;
   endtask

   task automatic frame(input bit poke);
      check_ends("draw", exp_pos);
      check_pulse();
      drive_line(3, exp_pos, 1'b1, 1'b0, poke);
      check("busy_hold", 64'(busy), 64'd1);
      wait_ls(20, poke, cyc);
      check("hold_len", 64'(cyc), 64'(HOLD));
      check("sb_drain_draw", 64'(sb.size()), 64'd0);
      check_ends("erase", exp_pos);
      check_pulse();
      drive_line(3, exp_pos + 1, 1'b0, 1'b1, 1'b0);
      wait_ls(10, 1'b0, cyc);
      check("step_len", 64'(cyc), 64'd1);
      check("sb_drain_erase", 64'(sb.size()), 64'd0);
      exp_pos = (exp_pos + STEPV > 639) ? 0 : exp_pos + STEPV;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      line_x     = '0;
      line_y     = '0;
      line_valid = 1'b0;
      line_done  = 1'b0;
      #12;
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", 64'(busy), 64'd0);

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("clear_en_rise", 64'(clear_en), 64'd1);
      check("busy_clear", 64'(busy), 64'd1);
      cyc = 0;
      while (wr_count < 1000 && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("clear_progress", 64'(wr_count >= 1000), 64'd1);
      reset = 1'b1;
      #1;
      check_all_zero("midclear_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      wr_count = 0;
      @(posedge clk); #1;

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_ls(3000, 1'b0, cyc);
      check("clear_writes", 64'(wr_count), 64'(CLR_WR));
      check("clear_first", 64'(first_w), 64'd0);
      check("clear_last", 64'(last_w), 64'({11'd639, 11'd479, 1'b0}));
      check("clear_en_drop", 64'(clear_en), 64'd0);
      check("sb_drain_clear", 64'(sb.size()), 64'd0);

      exp_pos = 0;
      for (int f = 0; f < 5; f++) frame(f == 1);
      check_ends("wrap", exp_pos);
      check("busy_loop", 64'(busy), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
